// File: rtl/mem_stage.sv
// Memory stage: data-memory access over a req/ready bus and MEM/WB bundle register.
// Stalls EX/MEM while an access is outstanding; timeouts and misalignment set a sticky error.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_in,
  input  logic        memwrite_in,
  input  logic [1:0]  wbselect_in,
  input  logic        regwrite_in,
  input  logic [4:0]  dst_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] wbdata_out,
  output logic        regwrite_out,
  output logic [4:0]  dst_out,
  output logic        err_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] wb_q, wb_d;
  logic        rw_q, rw_d;
  logic [4:0]  dst_q, dst_d;
  logic        err_q, err_d;
  logic        stall;
  logic        mem_op;
  logic        aligned;

  function automatic logic [31:0] wb_sel(
    input logic [1:0]  sel,
    input logic [31:0] alu,
    input logic [31:0] rdata,
    input logic [31:0] pc
  );
    unique case (sel)
      2'b00:   wb_sel = alu;
      2'b01:   wb_sel = rdata;
      2'b10:   wb_sel = pc + 32'd4;
      default: wb_sel = 32'd0;
    endcase
  endfunction

  assign mem_op  = valid_in & (memwrite_in | (wbselect_in == 2'b01));
  assign aligned = (alu_in[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    inst_d  = inst_q;
    pc_d    = pc_q;
    wb_d    = wb_q;
    rw_d    = 1'b0;
    dst_d   = dst_q;
    err_d   = err_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && aligned) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = memwrite_in;
          addr_d  = alu_in;
          wdata_d = rs2_in;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          inst_d = inst_in;
          pc_d   = pc_in;
          dst_d  = dst_in;
          if (mem_op) begin
            valid_d = 1'b1;
            wb_d    = 32'd0;
            err_d   = 1'b1;
          end else begin
            valid_d = valid_in;
            wb_d    = wb_sel(wbselect_in, alu_in, dmem_rdata, pc_in);
            rw_d    = valid_in & regwrite_in;
          end
        end
      end
      BUSY: begin
        if (dmem_ready || cnt_q == LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
          valid_d = 1'b1;
          inst_d  = inst_in;
          pc_d    = pc_in;
          dst_d   = dst_in;
          if (dmem_ready) begin
            wb_d = wb_sel(wbselect_in, alu_in, dmem_rdata, pc_in);
            rw_d = regwrite_in;
          end else begin
            wb_d  = 32'd0;
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      wb_q    <= '0;
      rw_q    <= 1'b0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      wb_q    <= wb_d;
      rw_q    <= rw_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
    end
  end

  // Gated so the stall is 0 while reset is held
  assign stall_out    = rst_n & stall;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign valid_out    = valid_q;
  assign inst_out     = inst_q;
  assign pc_out       = pc_q;
  assign wbdata_out   = wb_q;
  assign regwrite_out = rw_q;
  assign dst_out      = dst_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random ops checked
// against a per-transaction reference model.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic [31:0] alu_in;
  logic [31:0] rs2_in;
  logic        memwrite_in;
  logic [1:0]  wbselect_in;
  logic        regwrite_in;
  logic [4:0]  dst_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] wbdata_out;
  logic        regwrite_out;
  logic [4:0]  dst_out;
  logic        err_out;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .inst_in(inst_in), .pc_in(pc_in),
    .alu_in(alu_in), .rs2_in(rs2_in), .memwrite_in(memwrite_in),
    .wbselect_in(wbselect_in), .regwrite_in(regwrite_in),
    .dst_in(dst_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .valid_out(valid_out),
    .inst_out(inst_out), .pc_out(pc_out), .wbdata_out(wbdata_out),
    .regwrite_out(regwrite_out), .dst_out(dst_out), .err_out(err_out)
  );

  int   npass = 0;
  int   ntot  = 0;
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] wb_ref(input logic [1:0] sel,
    input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc);
    case (sel)
      2'd0:    return alu;
      2'd1:    return rd;
      2'd2:    return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  // rdy: BUSY cycle index (0-based) in which ready is raised; <0 = never
  task automatic run_op(input logic v, input logic mw,
    input logic [1:0] sel, input logic rw, input logic [4:0] dst,
    input logic [31:0] alu, input logic [31:0] rs2,
    input logic [31:0] pc, input logic [31:0] ins, input int rdy);
    logic        mem, mis, tout, ev;
    logic [31:0] rd;
    int          busy, reqs;
    valid_in = v; memwrite_in = mw; wbselect_in = sel;
    regwrite_in = rw; dst_in = dst; alu_in = alu; rs2_in = rs2;
    pc_in = pc; inst_in = ins; dmem_ready = 1'b0;
    rd = $urandom; dmem_rdata = rd;
    mem = v && (mw || sel == 2'b01);
    mis = mem && (alu[1:0] != 2'b00);
    @(negedge clk);
    check("stall_idle", stall_out, mem && !mis);
    check("req_idle", dmem_req, 0);
    if (!mem || mis) begin
      @(posedge clk); #1;
      ev = mem ? 1'b1 : v;
      check("valid", valid_out, ev);
      if (mis) begin
        exp_err = 1'b1;
        check("wb_mis", wbdata_out, 0);
        check("rw_mis", regwrite_out, 0);
      end else begin
        if (v) check("wb", wbdata_out, wb_ref(sel, alu, rd, pc));
        check("rw", regwrite_out, v & rw);
      end
    end else begin
      @(posedge clk); #1;
      check("valid_launch", valid_out, 0);
      tout = (rdy < 0) || (rdy >= TO);
      busy = tout ? TO : rdy + 1;
      reqs = 0;
      ev = 1'b1;
      for (int b = 0; b < busy; b++) begin
        if (b == rdy) dmem_ready = 1'b1;
        @(negedge clk);
        reqs += int'(dmem_req);
        if (b == 0) begin
          check("we", dmem_we, mw);
          check("addr", dmem_addr, alu);
          check("wdata", dmem_wdata, rs2);
        end
        check("stall_busy", stall_out, (b == rdy) ? 0 : (b < TO - 1));
        check("valid_busy", valid_out, 0);
        @(posedge clk); #1;
      end
      dmem_ready = 1'b0;
      check("req_cycles", reqs, busy);
      check("req_drop", dmem_req, 0);
      check("valid_done", valid_out, 1);
      if (tout) begin
        exp_err = 1'b1;
        check("wb_tout", wbdata_out, 0);
        check("rw_tout", regwrite_out, 0);
      end else begin
        check("wb_mem", wbdata_out, wb_ref(sel, alu, rd, pc));
        check("rw_mem", regwrite_out, rw);
      end
    end
    if (ev) begin
      check("dst", dst_out, dst);
      check("pc", pc_out, pc);
      check("inst", inst_out, ins);
    end
    check("err", err_out, exp_err);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 0; inst_in = 0; pc_in = 0; alu_in = 0;
    rs2_in = 0; memwrite_in = 0; wbselect_in = 0; regwrite_in = 0;
    dst_in = 0; dmem_ready = 0; dmem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_req", dmem_req, 0);
    check("rst_err", err_out, 0);
    check("rst_stall", stall_out, 0);
    check("rst_rw", regwrite_out, 0);
    check("rst_wb", wbdata_out, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1, 0, 2'b00, 1, 5'd5, 32'h1234, 0, 32'h10, 32'h13, 0);
    run_op(1, 0, 2'b01, 1, 5'd7, 32'h100, 0, 32'h14, 32'h3, 2);
    run_op(1, 1, 2'b00, 1, 5'd9, 32'h40, 32'hA5A5A5A5, 32'h18, 32'h23, 0);
    run_op(1, 0, 2'b01, 1, 5'd3, 32'h200, 0, 32'h1C, 32'h3, -1);

    // Late ready after a timeout must be ignored
    valid_in = 1'b0; dmem_ready = 1'b1;
    @(posedge clk); #1;
    check("late_valid", valid_out, 0);
    check("late_req", dmem_req, 0);
    dmem_ready = 1'b0;

    run_op(1, 0, 2'b01, 1, 5'd4, 32'h102, 0, 32'h20, 32'h3, 0);
    run_op(1, 0, 2'b10, 1, 5'd1, 32'h0, 0, 32'hFFFFFFFC, 32'h6F, 0);

    // Reset in the middle of a BUSY access
    valid_in = 1; memwrite_in = 0; wbselect_in = 2'b01; alu_in = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", dmem_req, 0);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_stall", stall_out, 0);
    check("mid_rst_err", err_out, 0);
    exp_err = 1'b0;
    valid_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 0, 2'b00, 1, 5'd11, 32'hCAFE0000, 0, 32'h40, 32'h33, 0);

    for (int i = 0; i < 60; i++) begin
      logic        v, mw, rw;
      logic [1:0]  sel;
      logic [31:0] alu;
      int          kind, rdy;
      kind = $urandom_range(0, 3);
      v = (kind != 3);
      mw = (kind == 2);
      sel = 2'($urandom_range(0, 3));
      if (kind == 0 && sel == 2'b01) sel = 2'b00;
      if (kind == 1) sel = 2'b01;
      rw = 1'($urandom_range(0, 1));
      alu = $urandom;
      if ($urandom_range(0, 9) != 0) alu[1:0] = 2'b00;
      rdy = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      run_op(v, mw, sel, rw, 5'($urandom), alu, $urandom,
             $urandom, $urandom, rdy);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
